// File: rtl/lsu_if.sv
// ----------------------------------------------------------------------------
// lsu_if
// Bundles the core-side request signals and the data-memory bus of the
// load/store unit.
//   slave  : the LSU itself (takes requests, drives the memory bus)
//   master : the surrounding core + memory (drives requests, answers the bus)
// Signals
//   req_valid/req_we/funct3/addr/wdata : access in execute stage
//   stall, rdata, rdata_valid          : core hold and load writeback
//   err_valid, err_code                : aborted-access pulse and cause
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : word-aligned memory request
//   mem_ready, mem_rdata               : memory completion and read word
// ----------------------------------------------------------------------------
interface lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_we;
    logic [2:0]              funct3;
    logic [DATA_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    stall;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rdata_valid;
    logic                    err_valid;
    logic [1:0]              err_code;
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic [3:0]              mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata, mem_ready, mem_rdata,
        output stall, rdata, rdata_valid, err_valid, err_code,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, funct3, addr, wdata, mem_ready, mem_rdata,
        input  stall, rdata, rdata_valid, err_valid, err_code,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu
// Load/store unit between the ALU and a variable-latency data memory.
// Issues word-aligned requests with byte enables, aligns and extends load
// data, stalls the core while an access is in flight, and reports
// misaligned / illegal-funct3 / timeout errors as one-cycle pulses.
// Ports
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : lsu_if.slave (core request side + memory bus)
// Parameters
//   DATA_WIDTH     : data/address width (32 only)
//   TIMEOUT_CYCLES : REQ cycles without mem_ready before a timeout error
// ----------------------------------------------------------------------------
module lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  err_code_d;
    logic        illegal, misaligned;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    // Byte enables for the access size at the given byte offset.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across all lanes so the memory picks it via mem_be.
    function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [1:0] size,
                                                          input logic [DATA_WIDTH-1:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Select the addressed byte/half and extend; funct3[2] selects zero-extension.
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00: begin
                if (f3[2]) return DATA_WIDTH'($unsigned(b));
                else       return DATA_WIDTH'(b);
            end
            2'b01: begin
                if (f3[2]) return DATA_WIDTH'($unsigned(h));
                else       return DATA_WIDTH'(h);
            end
            default: return word;
        endcase
    endfunction

    always_comb begin
        // Reserved sizes, and unsigned variants that only exist for loads.
        illegal    = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                     (bus.req_we && bus.funct3[2]);
        misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_code_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (illegal) begin
                        state_d    = ERR;
                        err_code_d = 2'b11;
                    end else if (misaligned) begin
                        state_d    = ERR;
                        err_code_d = 2'b01;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 8'd0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ERR;
                    err_code_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is the only combinational output: it must cover the accept cycle.
    assign bus.stall = ((state_q == IDLE) && bus.req_valid) || (state_q == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_be      <= 4'b0000;
            bus.mem_wdata   <= '0;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
            bus.err_valid   <= 1'b0;
            bus.err_code    <= 2'b00;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bus.mem_req     <= (state_d == REQ);
            bus.err_valid   <= (state_d == ERR);
            bus.err_code    <= err_code_d;
            bus.rdata_valid <= (state_q == REQ) && bus.mem_ready && !bus.mem_we;
            if ((state_q == IDLE) && (state_d == REQ)) begin
                bus.mem_we    <= bus.req_we;
                bus.mem_addr  <= {bus.addr[DATA_WIDTH-1:2], 2'b00};
                bus.mem_be    <= byte_en(bus.funct3[1:0], bus.addr[1:0]);
                bus.mem_wdata <= store_lanes(bus.funct3[1:0], bus.wdata);
                f3_q          <= bus.funct3;
                off_q         <= bus.addr[1:0];
            end
            // Load data is captured on the completing edge; rdata holds afterwards.
            if ((state_q == REQ) && bus.mem_ready && !bus.mem_we)
                bus.rdata <= load_extend(f3_q, off_q, bus.mem_rdata);
        end
    end

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu: reset state, a table of directed accesses,
// reset during an in-flight request, and randomized accesses checked against
// a size/offset arithmetic model.
// ----------------------------------------------------------------------------
module tb_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if #(.DATA_WIDTH(32)) bus();

    lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int TMO = 4;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          waits;
        logic [1:0]  ec;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
        int          stall;
    } vec_t;

    typedef struct {
        int          stall_n;
        int          req_n;
        int          pulses;
        int          ec_bad;
        logic        start_req;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  ec;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  be;
        logic        mwe;
        logic        unstable;
        logic        finished;
    } res_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Expected outcome from size/offset arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        e;
        int          size;
        int          off;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] val;
        e = v;
        size = 1 << v.f3[1:0];
        off = int'(v.addr % 4);
        if (v.we) legal = (v.f3 == 3'd0) || (v.f3 == 3'd1) || (v.f3 == 3'd2);
        else      legal = (v.f3 == 3'd0) || (v.f3 == 3'd1) || (v.f3 == 3'd2) ||
                          (v.f3 == 3'd4) || (v.f3 == 3'd5);
        if (!legal) begin
            e.ec = 2'd3; e.stall = 1;
        end else if ((v.addr % size) != 0) begin
            e.ec = 2'd1; e.stall = 1;
        end else if (v.waits >= TMO) begin
            e.ec = 2'd2; e.stall = TMO + 1;
        end else begin
            e.ec = 2'd0; e.stall = v.waits + 2;
        end
        e.be = 4'(((1 << size) - 1) << off);
        e.mwdata = 32'h0;
        for (int i = 0; i < 4; i++)
            e.mwdata = e.mwdata | (((v.wdata >> (8 * (i % size))) & 32'hFF) << (8 * i));
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val = (v.word >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        e.rdata = val;
        return e;
    endfunction

    // Drive one instruction; req_valid stays high through its retiring cycle.
    task automatic run_op(input vec_t v, input bit noise, output res_t r);
        r = '{default: '0};
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.req_valid = 1'b1;
                bus.req_we    = v.we;
                bus.funct3    = v.f3;
                bus.addr      = v.addr;
                bus.wdata     = v.wdata;
            end
            bus.mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
            #1;
            if (k == 0 && bus.mem_req) r.start_req = 1'b1;
            if (bus.stall) r.stall_n++;
            if (!bus.err_valid && bus.err_code != 2'b00) r.ec_bad++;
            if (bus.rdata_valid) begin
                r.pulses++; r.rv = 1'b1; r.rdata = bus.rdata;
            end
            if (bus.err_valid) begin
                r.pulses++; r.err = 1'b1; r.ec = bus.err_code;
            end
            if (bus.mem_req) begin
                r.req_n++;
                if (r.req_n == 1) begin
                    r.maddr = bus.mem_addr; r.mwdata = bus.mem_wdata;
                    r.be = bus.mem_be; r.mwe = bus.mem_we;
                end else if (r.maddr !== bus.mem_addr || r.mwdata !== bus.mem_wdata ||
                             r.be !== bus.mem_be || r.mwe !== bus.mem_we) begin
                    r.unstable = 1'b1;
                end
                if (r.req_n > v.waits) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = v.word;
                end else begin
                    bus.mem_ready = 1'b0;
                end
            end
            if (k > 0 && !bus.stall) begin
                r.finished = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input vec_t e, input res_t r);
        int exp_req;
        exp_req = (e.ec == 2'd2) ? TMO : ((e.ec == 2'd0) ? e.waits + 1 : 0);
        chk({tag, " finished"}, 32'(r.finished), 32'd1);
        chk({tag, " mem_req_at_accept"}, 32'(r.start_req), 32'd0);
        chk({tag, " err_code"}, 32'(r.err ? r.ec : 2'b00), 32'(e.ec));
        chk({tag, " stall_cycles"}, r.stall_n, e.stall);
        chk({tag, " req_cycles"}, r.req_n, exp_req);
        chk({tag, " pulses"}, r.pulses, (e.we && e.ec == 2'd0) ? 0 : 1);
        chk({tag, " err_code_idle"}, r.ec_bad, 0);
        chk({tag, " rdata_valid"}, 32'(r.rv), 32'(!e.we && e.ec == 2'd0));
        if (exp_req > 0) begin
            chk({tag, " mem_addr"}, r.maddr, {e.addr[31:2], 2'b00});
            chk({tag, " mem_be"}, 32'(r.be), 32'(e.be));
            chk({tag, " mem_we"}, 32'(r.mwe), 32'(e.we));
            chk({tag, " stable"}, 32'(r.unstable), 32'd0);
            if (e.we) chk({tag, " mem_wdata"}, r.mwdata, e.mwdata);
        end
        if (!e.we && e.ec == 2'd0) chk({tag, " rdata"}, r.rdata, e.rdata);
    endtask

    vec_t tbl[16];
    vec_t v, e;
    res_t r;

    initial begin
        // we, f3, addr, wdata, word, waits | ec, rdata, be, mwdata, stall
        tbl[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2'd0, 32'hDEADBEEF, 4'hF, 32'h0,        2};
        tbl[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF0000, 0, 2'd0, 32'hFFFFFF80, 4'h8, 32'h0,        2};
        tbl[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF0000, 0, 2'd0, 32'h00000080, 4'h8, 32'h0,        2};
        tbl[3]  = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,        0, 2'd0, 32'h0,        4'hC, 32'hABCDABCD, 2};
        tbl[4]  = '{1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 2'd1, 32'h0,        4'h0, 32'h0,        1};
        tbl[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80011234, 2, 2'd0, 32'hFFFF8001, 4'hC, 32'h0,        4};
        tbl[6]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h80011234, 1, 2'd0, 32'h00008001, 4'hC, 32'h0,        3};
        tbl[7]  = '{1'b1, 3'd0, 32'h001, 32'h000000A5, 32'h0,        0, 2'd0, 32'h0,        4'h2, 32'hA5A5A5A5, 2};
        tbl[8]  = '{1'b0, 3'd3, 32'h000, 32'h0,        32'h0,        0, 2'd3, 32'h0,        4'h0, 32'h0,        1};
        tbl[9]  = '{1'b1, 3'd4, 32'h000, 32'h0,        32'h0,        0, 2'd3, 32'h0,        4'h0, 32'h0,        1};
        tbl[10] = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        0, 2'd1, 32'h0,        4'h0, 32'h0,        1};
        tbl[11] = '{1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0,        3, 2'd0, 32'h0,        4'hF, 32'hCAFEF00D, 5};
        tbl[12] = '{1'b0, 3'd7, 32'h003, 32'h0,        32'h0,        0, 2'd3, 32'h0,        4'h0, 32'h0,        1};
        tbl[13] = '{1'b0, 3'd0, 32'h001, 32'h0,        32'h12345680, 0, 2'd0, 32'h00000056, 4'h2, 32'h0,        2};
        tbl[14] = '{1'b0, 3'd1, 32'h000, 32'h0,        32'h0,        9, 2'd2, 32'h0,        4'h3, 32'h0,        5};
        tbl[15] = '{1'b1, 3'd2, 32'h302, 32'h0,        32'h0,        0, 2'd1, 32'h0,        4'h0, 32'h0,        1};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.funct3 = 3'd0;
        bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset rdata_valid", 32'(bus.rdata_valid), 32'd0);
        chk("reset err_valid", 32'(bus.err_valid), 32'd0);
        chk("reset err_code", 32'(bus.err_code), 32'd0);
        chk("reset rdata", bus.rdata, 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        chk("reset mem_be", 32'(bus.mem_be), 32'd0);
        rst = 1'b0;

        // Directed table, issued back to back.
        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i], 1'b0, r);
            check_op($sformatf("tbl%0d", i), tbl[i], r);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("idle after table mem_req", 32'(bus.mem_req), 32'd0);
        chk("idle after table stall", 32'(bus.stall), 32'd0);

        // Reset while a load is waiting in REQ.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.funct3 = 3'd2;
        bus.addr = 32'h400; bus.mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("rstreq mem_req", 32'(bus.mem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk); #1;
        chk("rstreq mem_req after", 32'(bus.mem_req), 32'd0);
        chk("rstreq stall", 32'(bus.stall), 32'd0);
        chk("rstreq rdata_valid", 32'(bus.rdata_valid), 32'd0);
        chk("rstreq err_valid", 32'(bus.err_valid), 32'd0);
        chk("rstreq rdata", bus.rdata, 32'd0);
        chk("rstreq mem_addr", bus.mem_addr, 32'd0);
        chk("rstreq mem_we", 32'(bus.mem_we), 32'd0);
        rst = 1'b0;
        v = '{1'b1, 3'd2, 32'h500, 32'h13579BDF, 32'h0, 0, 2'd0, 32'h0, 4'hF, 32'h13579BDF, 2};
        run_op(v, 1'b0, r);
        check_op("sw_after_rst", v, r);

        // Randomized accesses with mem_ready noise outside REQ.
        for (int i = 0; i < 300; i++) begin
            v = '{default: '0};
            v.we    = 1'($urandom_range(0, 1));
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.word  = $urandom;
            v.waits = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
            e = model(v);
            run_op(v, 1'b1, r);
            check_op($sformatf("rnd%0d", i), e, r);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
